// File: rtl/sequence_playback_scheduler.sv
// sequence_playback_scheduler: steps sequence memory 0..last and lights each entry for ON_CYCLES clocks
// Optional blank gap of OFF_CYCLES after every entry when PLAYBACK_BLANK_EN is defined.
module sequence_playback_scheduler #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] leds,
  output logic              busy,
  output logic              done,
  output logic [3:0]        db_estado
);
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FETCH = 4'd1,
    WAIT  = 4'd2,
    SHOW  = 4'd3,
    GAP   = 4'd4,
    NEXT  = 4'd5,
    DONE  = 4'd6
  } state_t;
  localparam int CMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] last_q;
  logic at_last;
  assign at_last   = mem_addr == last_q;
  assign db_estado = state;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_addr <= '0;
      leds     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      last_q   <= '0;
    end else if (abort && state != IDLE) begin
      state    <= IDLE;
      mem_addr <= '0;
      leds     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (start && !abort) begin
          last_q   <= last_addr;
          mem_addr <= '0;
          busy     <= 1'b1;
          state    <= FETCH;
        end
        FETCH: state <= WAIT;
        WAIT: begin
          leds  <= mem_data;
          cnt   <= '0;
          state <= SHOW;
        end
        SHOW: if (cnt == CW'(ON_CYCLES - 1)) begin
          leds <= '0;
          cnt  <= '0;
`ifdef PLAYBACK_BLANK_EN
          state <= GAP;
`else
          state <= at_last ? DONE : NEXT;
          done  <= at_last;
`endif
        end else begin
          cnt <= cnt + 1'b1;
        end
`ifdef PLAYBACK_BLANK_EN
        GAP: if (cnt == CW'(OFF_CYCLES - 1)) begin
          cnt   <= '0;
          state <= at_last ? DONE : NEXT;
          done  <= at_last;
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
        NEXT: begin
          mem_addr <= mem_addr + 1'b1;
          state    <= FETCH;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          leds  <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sequence_playback_scheduler.sv
// tb_sequence_playback_scheduler: directed checks of playback timing, abort, async reset and ignored inputs
module tb_sequence_playback_scheduler;
  localparam int AW = 4, DW = 4, ON = 4, OFF = 2;
`ifdef PLAYBACK_BLANK_EN
  localparam int PER = ON + OFF + 3;
`else
  localparam int PER = ON + 3;
`endif
  logic clock = 0, reset = 0, start = 0, abort = 0;
  logic [AW-1:0] last_addr = 0;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] leds;
  logic busy, done;
  logic [3:0] db_estado;
  logic [DW-1:0] mem [16];
  int checks = 0, fails = 0;

  sequence_playback_scheduler #(.ADDR_W(AW), .DATA_W(DW), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .last_addr(last_addr),
    .mem_data(mem_data), .mem_addr(mem_addr), .leds(leds), .busy(busy), .done(done),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) mem_data <= mem[mem_addr];

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({mem_addr, leds, busy, done, db_estado} !== '0) begin
      fails++;
      $display("FAIL reset: addr=%h leds=%h busy=%b done=%b st=%0d, want all 0", mem_addr, leds, busy, done, db_estado);
    end
    reset = 1;
    @(negedge clock);
  endtask

  // cycle k = k-th clock after the edge that samples start; entry e occupies clocks e*PER+1 .. (e+1)*PER
  task automatic run_play(input int last, input bit disturb, input string name);
    int n, e, p;
    logic [DW-1:0] el;
    logic [AW-1:0] ea;
    logic [3:0] es;
    n = last + 1;
    last_addr = AW'(last);
    start = 1;
    @(negedge clock);
    start = 0;
    for (int k = 1; k <= n * PER + 1; k++) begin
      e = (k - 1) / PER;
      p = (k - 1) % PER;
      el = (k <= n * PER && p >= 2 && p <= ON + 1) ? mem[e] : '0;
      ea = (k > n * PER) ? AW'(n - 1) : AW'(e);
      es = (k > n * PER) ? 4'd0 : p == 0 ? 4'd1 : p == 1 ? 4'd2 : p <= ON + 1 ? 4'd3 :
           p == PER - 1 ? (e == n - 1 ? 4'd6 : 4'd5) : 4'd4;
      checks++;
      if (leds !== el) begin
        fails++;
        $display("FAIL %s leds k=%0d: got %h want %h", name, k, leds, el);
      end
      checks++;
      if (mem_addr !== ea) begin
        fails++;
        $display("FAIL %s addr k=%0d: got %h want %h", name, k, mem_addr, ea);
      end
      checks++;
      if (busy !== (k <= n * PER)) begin
        fails++;
        $display("FAIL %s busy k=%0d: got %b want %b", name, k, busy, k <= n * PER);
      end
      checks++;
      if (done !== (k == n * PER)) begin
        fails++;
        $display("FAIL %s done k=%0d: got %b want %b", name, k, done, k == n * PER);
      end
      checks++;
      if (db_estado !== es) begin
        fails++;
        $display("FAIL %s state k=%0d: got %0d want %0d", name, k, db_estado, es);
      end
      if (disturb) begin
        start = (k == 20 || k == 60);
        if (k == 30) last_addr = 4'd3;
      end
      @(negedge clock);
    end
    start = 0;
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    for (int k = 0; k < cycles; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL %s quiet k=%0d: done=%b busy=%b want 0 0", name, k, done, busy);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_start_abort_idle();
    last_addr = 4'd2;
    start = 1;
    abort = 1;
    @(negedge clock);
    start = 0;
    abort = 0;
    checks++;
    if (db_estado !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_abort_idle: st=%0d busy=%b want 0 0", db_estado, busy);
    end
    expect_quiet(3, "start_abort_idle");
  endtask

  task automatic test_abort();
    last_addr = 4'd2;
    start = 1;
    @(negedge clock);
    start = 0;
    for (int k = 1; k < PER + 4; k++) @(negedge clock);
    checks++;
    if (db_estado !== 4'd3 || mem_addr !== 4'd1) begin
      fails++;
      $display("FAIL abort setup: st=%0d addr=%h want 3 1", db_estado, mem_addr);
    end
    abort = 1;
    @(negedge clock);
    abort = 0;
    checks++;
    if ({db_estado, leds, busy, done, mem_addr} !== '0) begin
      fails++;
      $display("FAIL abort: st=%0d leds=%h busy=%b done=%b addr=%h want all 0", db_estado, leds, busy, done, mem_addr);
    end
    expect_quiet(3 * PER, "abort");
    run_play(2, 0, "replay");
  endtask

  task automatic test_async_reset();
    last_addr = 4'd2;
    start = 1;
    @(negedge clock);
    start = 0;
`ifdef PLAYBACK_BLANK_EN
    for (int k = 1; k < 8; k++) @(negedge clock);
    checks++;
    if (db_estado !== 4'd4) begin
      fails++;
      $display("FAIL async_reset setup: st=%0d want 4", db_estado);
    end
`else
    for (int k = 1; k < 5; k++) @(negedge clock);
`endif
    reset = 0;
    #1;
    checks++;
    if ({db_estado, leds, busy, done, mem_addr} !== '0) begin
      fails++;
      $display("FAIL async_reset: st=%0d leds=%h busy=%b done=%b addr=%h want all 0", db_estado, leds, busy, done, mem_addr);
    end
    @(negedge clock);
    reset = 1;
    expect_quiet(3 * PER, "async_reset");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(1 << (i % 4));
    test_reset();
    run_play(2, 0, "basic");
    run_play(0, 0, "single");
    test_start_abort_idle();
    test_abort();
    test_async_reset();
    run_play(15, 1, "full_range");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
